// File: rtl/rv_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for the R/I-type RISC-V datapath.
// Optional feature: define RV_SEQ_TRAP_EN to halt with a sticky trap on illegal opcodes.
module rv_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        rf_we,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic [31:0] imm,
  output logic        busy,
  output logic        halted,
  output logic        trap,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_SYS = 7'b1110011;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic        req_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [3:0]  op_q;
  logic        src_q;
  logic [31:0] imm_q;
  logic        busy_q;
  logic        halted_q;
  logic        trap_q;
  logic [31:0] instret_q;
  logic        nop_q;

  logic        is_r_d;
  logic        is_i_d;
  logic        is_sys_d;
  logic        is_ill_d;
  logic [3:0]  op_d;
  logic [31:0] imm_d;
  logic [31:0] pc_inc_d;

  always_comb begin
    is_r_d   = (ir_q[6:0] == OPC_R);
    is_i_d   = (ir_q[6:0] == OPC_I);
    is_sys_d = (ir_q[6:0] == OPC_SYS);
    is_ill_d = !(is_r_d || is_i_d || is_sys_d);
    op_d     = 4'b0000;
    // Only the shift-right immediates carry the arithmetic/logical select in ir[30].
    if (is_r_d) begin
      op_d = {ir_q[30], ir_q[14:12]};
    end else if (is_i_d) begin
      op_d = (ir_q[14:12] == 3'b101) ? {ir_q[30], ir_q[14:12]} : {1'b0, ir_q[14:12]};
    end
    imm_d    = {{20{ir_q[31]}}, ir_q[31:20]};
    pc_inc_d = pc_q + 32'd4;
  end

  // The instruction register is pure data; it is only meaningful after a fetch.
  always_ff @(posedge clk) begin
    if (state_q == S_FETCH && imem_ack) begin
      ir_q <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rd_q      <= 5'd0;
      we_q      <= 1'b0;
      op_q      <= 4'd0;
      src_q     <= 1'b0;
      imm_q     <= 32'd0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      trap_q    <= 1'b0;
      instret_q <= 32'd0;
      nop_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q    <= RESET_PC;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          rs1_q <= ir_q[19:15];
          rs2_q <= ir_q[24:20];
          rd_q  <= ir_q[11:7];
          op_q  <= op_d;
          src_q <= is_i_d;
          imm_q <= imm_d;
          nop_q <= is_ill_d;
          if (is_sys_d) begin
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else if (is_ill_d) begin
`ifdef RV_SEQ_TRAP_EN
            trap_q   <= 1'b1;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            state_q  <= S_HALT;
`else
            state_q  <= S_EXEC;
`endif
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Writes to x0 and NOP'd illegal words never reach the register file.
          we_q    <= (rd_q != 5'd0) && !nop_q;
          state_q <= S_WB;
        end
        S_WB: begin
          we_q      <= 1'b0;
          pc_q      <= pc_inc_d;
          instret_q <= instret_q + 32'd1;
          req_q     <= 1'b1;
          state_q   <= S_FETCH;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign rs1_addr    = rs1_q;
  assign rs2_addr    = rs2_q;
  assign rd_addr     = rd_q;
  assign rf_we       = we_q;
  assign alu_op      = op_q;
  assign alu_src_imm = src_q;
  assign imm         = imm_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign trap        = trap_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_rv_seq_ctrl.sv
// Bench for rv_seq_ctrl: table-driven instruction vectors with a scoreboard queue,
// plus hand-written halt, illegal-opcode, mid-fetch reset and PC-wrap sequences.
module tb_rv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, rf_we, alu_src_imm, busy, halted, trap;
  logic [31:0] imem_addr, imm, instret;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [3:0]  alu_op;

  logic        w_start;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_req, w_rf_we, w_src, w_busy, w_halted, w_trap;
  logic [31:0] w_addr, w_imm, w_instret;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [3:0]  w_op;

  always #5 clk = ~clk;

  rv_seq_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rf_we(rf_we),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm(imm),
    .busy(busy), .halted(halted), .trap(trap), .instret(instret)
  );

  rv_seq_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(w_start),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .rs1_addr(w_rs1), .rs2_addr(w_rs2), .rd_addr(w_rd), .rf_we(w_rf_we),
    .alu_op(w_op), .alu_src_imm(w_src), .imm(w_imm),
    .busy(w_busy), .halted(w_halted), .trap(w_trap), .instret(w_instret)
  );

  typedef struct {
    logic [31:0] instr;
    int          waits;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic        src;
    logic [31:0] imm;
    logic        we;
  } vec_t;

  vec_t        vecs[7];
  vec_t        sbq[$];
  vec_t        v_ill;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the edge that put the DUT in FETCH.
  task automatic run_instr(input vec_t v, input bit chk_dec, input bit hold_start);
    vec_t e;
    for (int w = 0; w < v.waits; w++) begin
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, exp_pc);
      start    = hold_start;
      imem_ack = 1'b0;
      tick();
    end
    start = 1'b0;
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = v.instr;
    sbq.push_back(v);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("decode_req", imem_req, 0);
    chk("decode_busy", busy, 1);
    tick();
    chk("exec_rf_we", rf_we, 0);
    if (chk_dec) begin
      chk("exec_rs1", rs1_addr, sbq[0].rs1);
      chk("exec_rs2", rs2_addr, sbq[0].rs2);
      chk("exec_rd", rd_addr, sbq[0].rd);
      chk("exec_alu_op", alu_op, sbq[0].op);
      chk("exec_src_imm", alu_src_imm, sbq[0].src);
      chk("exec_imm", imm, sbq[0].imm);
    end
    tick();
    e = sbq.pop_front();
    chk("wb_rf_we", rf_we, e.we);
    chk("wb_instret", instret, exp_instret);
    tick();
    exp_pc      = exp_pc + 32'd4;
    exp_instret = exp_instret + 32'd1;
    chk("next_rf_we", rf_we, 0);
    chk("next_instret", instret, exp_instret);
    chk("next_addr", imem_addr, exp_pc);
    chk("next_req", imem_req, 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_pc      = 32'd0;
    exp_instret = 32'd0;
    chk("start_req", imem_req, 1);
    chk("start_addr", imem_addr, 32'd0);
    chk("start_busy", busy, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h00500093, 0, 5'd0, 5'd5,  5'd1,  4'b0000, 1'b1, 32'h0000_0005, 1'b1};
    vecs[1] = '{32'h402081B3, 3, 5'd1, 5'd2,  5'd3,  4'b1000, 1'b0, 32'h0000_0402, 1'b1};
    vecs[2] = '{32'h40235293, 1, 5'd6, 5'd2,  5'd5,  4'b1101, 1'b1, 32'h0000_0402, 1'b1};
    vecs[3] = '{32'h00100013, 0, 5'd0, 5'd1,  5'd0,  4'b0000, 1'b1, 32'h0000_0001, 1'b0};
    vecs[4] = '{32'hFFF08113, 2, 5'd1, 5'd31, 5'd2,  4'b0000, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{32'h009473B3, 0, 5'd8, 5'd9,  5'd7,  4'b0111, 1'b0, 32'h0000_0009, 1'b1};
    vecs[6] = '{32'h00359513, 1, 5'd11, 5'd3, 5'd10, 4'b0001, 1'b1, 32'h0000_0003, 1'b1};
    v_ill   = '{32'hFFFF_FFFF, 0, 5'd31, 5'd31, 5'd31, 4'b0000, 1'b0, 32'hFFFF_FFFF, 1'b0};

    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    w_start = 1'b0; w_ack = 1'b1; w_rdata = 32'h00100093;
    exp_pc = 32'd0; exp_instret = 32'd0;
    tick();
    tick();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_rs1", rs1_addr, 0);
    chk("rst_rs2", rs2_addr, 0);
    chk("rst_rd", rd_addr, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_src_imm", alu_src_imm, 0);
    chk("rst_imm", imm, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_trap", trap, 0);
    chk("rst_instret", instret, 0);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_req", imem_req, 0);

    do_start();
    for (int i = 0; i < 7; i++) run_instr(vecs[i], 1'b1, 1'b1);

    // System opcode halts without retiring.
    imem_ack = 1'b1; imem_rdata = 32'h0000_0073;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("halt_halted", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_instret", instret, exp_instret);
    chk("halt_addr", imem_addr, exp_pc);
    chk("halt_req", imem_req, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("halt_start_halted", halted, 1);
    chk("halt_start_req", imem_req, 0);
    chk("halt_start_addr", imem_addr, exp_pc);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_instret", instret, 0);
    chk("halt_rst_busy", busy, 0);

    // All-ones word: illegal opcode.
    do_start();
`ifdef RV_SEQ_TRAP_EN
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("ill_trap", trap, 1);
    chk("ill_halted", halted, 1);
    chk("ill_busy", busy, 0);
    chk("ill_instret", instret, 0);
    chk("ill_addr", imem_addr, 0);
    tick();
    chk("ill_rf_we", rf_we, 0);
`else
    run_instr(v_ill, 1'b0, 1'b0);
    chk("ill_trap", trap, 0);
    chk("ill_halted", halted, 0);
    run_instr(vecs[0], 1'b1, 1'b0);
`endif

    // Reset while a fetch request is pending.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    do_start();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midfetch_req", imem_req, 0);
    chk("midfetch_busy", busy, 0);
    chk("midfetch_addr", imem_addr, 0);
    chk("midfetch_rf_we", rf_we, 0);

    // PC wrap: second instance starts at the last word address.
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    chk("wrap_start_addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap_start_req", w_req, 1);
    tick();
    tick();
    tick();
    chk("wrap_rf_we", w_rf_we, 1);
    tick();
    chk("wrap_addr", w_addr, 32'd0);
    chk("wrap_instret", w_instret, 1);

    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_seq_ctrl.md
# rv_seq_ctrl

Multi-cycle control sequencer for the R-type/I-type RISC-V datapath. Fetches 32-bit instructions from the instruction memory via a req/ack handshake, decodes them, and steps the register file and ALU through FETCH, DECODE, EXEC and WB phases. It maintains the PC and a retired-instruction counter, and signals halt or illegal-instruction conditions to the testbench and top level.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset and on `start`.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; leaves IDLE and begins fetching at `RESET_PC`.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, equal to PC.
- `imem_ack` in 1: fetch data valid.
- `imem_rdata` in 32: instruction word.
- `rs1_addr` out 5: register-file read address, `ir[19:15]`.
- `rs2_addr` out 5: register-file read address, `ir[24:20]`.
- `rd_addr` out 5: register-file write address, `ir[11:7]`.
- `rf_we` out 1: register-file write enable, asserted for one cycle.
- `alu_op` out 4: ALU operation code.
- `alu_src_imm` out 1: 1 selects `imm` as ALU operand 2; 0 selects rs2 data.
- `imm` out 32: sign-extended `ir[31:20]`.
- `busy` out 1: high in every state except IDLE and HALT.
- `halted` out 1: high in HALT.
- `trap` out 1: sticky illegal-opcode flag.
- `instret` out 32: count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE:
  - `start=1` loads PC to `RESET_PC` and moves to FETCH.
  - Otherwise stays in IDLE.
- FETCH:
  - Asserts `imem_req`; `imem_addr` holds PC.
  - On `imem_ack=1`, captures `imem_rdata` into IR and moves to DECODE.
  - Otherwise stays in FETCH, holding req and address stable.
- DECODE, by `ir[6:0]`:
  - 7'b0110011 (R-type): `alu_op={ir[30],ir[14:12]}`, `alu_src_imm=0`.
  - 7'b0010011 (I-type): `alu_src_imm=1`. `alu_op={ir[30],ir[14:12]}` when `funct3=3'b101`; otherwise `{1'b0,ir[14:12]}`.
  - 7'b1110011: go to HALT; PC and `instret` unchanged.
  - Any other opcode: see Configuration.
- Decode outputs (`rs*`, `rd_addr`, `alu_op`, `alu_src_imm`, `imm`) are registered. They are valid from the first cycle of EXEC until the next DECODE.
- EXEC: one cycle in which the ALU settles; moves to WB.
- WB:
  - `rf_we=1` only if `rd_addr != 0`.
  - PC advances by 4; `instret` increments by 1.
  - Moves to FETCH.
- HALT: terminal. Leaves only on `rst_n=0`; `start` is ignored.
- Arithmetic:
  - PC increments modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - `instret` wraps from 32'hFFFF_FFFF to 0.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE.
  - `imem_req=0`, `imem_addr=RESET_PC`.
  - `rs1_addr=rs2_addr=rd_addr=0`, `rf_we=0`, `alu_op=0`, `alu_src_imm=0`, `imm=0`.
  - `busy=0`, `halted=0`, `trap=0`, `instret=0`.
- `imem_ack` may be high in the same cycle `imem_req` first rises (zero-wait memory).
- Minimum latency is 4 cycles per instruction (FETCH, DECODE, EXEC, WB). Each wait cycle adds 1.
- `imem_ack` is ignored outside FETCH.
- `start` is ignored outside IDLE.
- `rst_n=0` in any state, including mid-fetch with req pending, returns to IDLE on the next edge. `imem_req` and `rf_we` are low from that edge.
- `rf_we` is never high for two consecutive cycles.

## Configuration
- `RV_SEQ_TRAP_EN` defined:
  - An illegal opcode sets `trap=1` and goes to HALT.
  - No `rf_we`; PC and `instret` are unchanged.
- `RV_SEQ_TRAP_EN` undefined:
  - An illegal opcode is a NOP: EXEC and WB run with `rf_we=0`.
  - PC advances by 4 and `instret` increments.
  - `trap` stays 0.

## Test plan
- Reset then `start`, zero-wait memory, `addi x1,x0,5` (32'h00500093):
  - `imem_addr=0`.
  - 4 cycles later, `rf_we=1`, `rd_addr=1`, `alu_src_imm=1`, `imm=5`, `alu_op=4'b0000`.
  - `instret=1`; next `imem_addr=4`.
- `sub x3,x1,x2` (32'h402081B3) with `imem_ack` delayed 3 cycles:
  - `imem_req` and `imem_addr` are stable for all 3 wait cycles.
  - `alu_op=4'b1000`, `alu_src_imm=0`, `rs1_addr=1`, `rs2_addr=2`.
  - Total 7 cycles to `rf_we`.
- `srai x5,x6,2` (32'h40235293):
  - `alu_op=4'b1101`, `imm=32'h402`.
- `addi x0,x0,1`:
  - Runs through WB with `rf_we=0`; `instret` increments.
- Opcode 7'b1110011:
  - `halted=1`, `busy=0`.
  - A later `start` pulse has no effect; `rst_n=0` returns to IDLE with `instret=0`.
- Word 32'hFFFFFFFF:
  - With `RV_SEQ_TRAP_EN`: `trap=1`, `halted=1`, `instret` unchanged.
  - Without `RV_SEQ_TRAP_EN`: `instret` increments, PC advances by 4, `trap=0`.
